// File: rtl/ysyx_22041211_fetch_seq_if.sv
// Fetch sequencer bus bundle: PC register hookup, memory request/response and decode handoff.
// The master side is the fetch sequencer; the slave side is its environment.
interface ysyx_22041211_fetch_seq_if #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
);
   logic [ADDR_LEN-1:0] pc;
   logic [ADDR_LEN-1:0] pc_new;
   logic                pc_wen;
   logic                req_valid;
   logic [ADDR_LEN-1:0] req_addr;
   logic                req_ready;
   logic                rsp_valid;
   logic [DATA_LEN-1:0] rsp_data;
   logic                rsp_err;
   logic                inst_valid;
   logic [DATA_LEN-1:0] inst;
   logic [ADDR_LEN-1:0] inst_pc;
   logic                inst_ready;
   logic                redirect_valid;
   logic [ADDR_LEN-1:0] redirect_target;
   logic                fetch_fault;

   modport master (
      input  pc,
      output pc_new, pc_wen,
      output req_valid, req_addr,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_err,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      input  redirect_valid, redirect_target,
      output fetch_fault
   );

   modport slave (
      output pc,
      input  pc_new, pc_wen,
      input  req_valid, req_addr,
      output req_ready,
      output rsp_valid, rsp_data, rsp_err,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      output redirect_valid, redirect_target,
      input  fetch_fault
   );
endinterface

// File: rtl/ysyx_22041211_fetch_seq.sv
// Instruction fetch sequencer: one outstanding fetch, holds the instruction for decode,
// and steers the external PC register on advance, redirect and fault recovery.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// REQ   | presenting fetch request for the current pc
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction held and offered to decode
// FAULT | misaligned pc or bus error; waiting for a redirect
module ysyx_22041211_fetch_seq #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input logic                       clk,
   input logic                       rst,
   ysyx_22041211_fetch_seq_if.master bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] FAULT = 3'd4;

   logic [2:0]          state;
   logic [2:0]          state_nx;
   logic [DATA_LEN-1:0] inst_q;
   logic [ADDR_LEN-1:0] inst_pc_q;
   logic [ADDR_LEN-1:0] pend_target;
   logic                pend_valid;
   logic                pc_wen;
   logic [ADDR_LEN-1:0] pc_new;
   logic                req_valid;
   logic                inst_valid;
   logic                aligned;

   assign aligned = (bus.pc[1:0] == 2'b00);

   always_comb begin
      state_nx   = state;
      pc_wen     = 1'b0;
      pc_new     = bus.pc;
      req_valid  = 1'b0;
      inst_valid = 1'b0;
      case (state)
         IDLE: state_nx = REQ;
         REQ: begin
            // a redirect pre-empts the request so the new pc is fetched instead
            if (bus.redirect_valid) begin
               pc_wen = 1'b1;
               pc_new = bus.redirect_target;
            end else if (!aligned) begin
               state_nx = FAULT;
            end else begin
               req_valid = 1'b1;
               if (bus.req_ready) state_nx = WAIT;
            end
         end
         WAIT: begin
            if (bus.rsp_valid) begin
               if (bus.redirect_valid || pend_valid) begin
                  pc_wen   = 1'b1;
                  pc_new   = bus.redirect_valid ? bus.redirect_target : pend_target;
                  state_nx = REQ;
               end else if (bus.rsp_err) begin
                  state_nx = FAULT;
               end else begin
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.redirect_valid) begin
               pc_wen   = 1'b1;
               pc_new   = bus.redirect_target;
               state_nx = REQ;
            end else begin
               inst_valid = 1'b1;
               if (bus.inst_ready) begin
                  pc_wen   = 1'b1;
                  pc_new   = bus.pc + ADDR_LEN'(4);
                  state_nx = REQ;
               end
            end
         end
         FAULT: begin
            if (bus.redirect_valid) begin
               pc_wen   = 1'b1;
               pc_new   = bus.redirect_target;
               state_nx = REQ;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         inst_q      <= '0;
         inst_pc_q   <= '0;
         pend_target <= '0;
         pend_valid  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == WAIT) begin
            if (bus.rsp_valid) begin
               pend_valid <= 1'b0;
            end else if (bus.redirect_valid) begin
               pend_valid  <= 1'b1;
               pend_target <= bus.redirect_target;
            end
         end
         if (state == WAIT && state_nx == HOLD) begin
            inst_q    <= bus.rsp_data;
            inst_pc_q <= bus.pc;
         end
      end
   end

   assign bus.pc_wen      = pc_wen;
   assign bus.pc_new      = pc_new;
   assign bus.req_valid   = req_valid;
   assign bus.req_addr    = bus.pc;
   assign bus.inst_valid  = inst_valid;
   assign bus.inst        = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign bus.fetch_fault = (state == FAULT);
endmodule

// File: tb/tb_ysyx_22041211_fetch_seq.sv
// Bench for the fetch sequencer: directed vector table, corner sequences and random
// stimulus against a transaction-level model; the bench also plays the PC register.
module tb_ysyx_22041211_fetch_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_22041211_fetch_seq_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();
   ysyx_22041211_fetch_seq #(.ADDR_LEN(32), .DATA_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // sampled DUT outputs
   logic        s_rv, s_wen, s_iv, s_flt;
   logic [31:0] s_addr, s_new, s_inst, s_ipc;

   // model: what the fetcher is doing, as plain flags plus a pending-redirect queue
   bit          m_boot, m_fault, m_out, m_hold;
   logic [31:0] m_inst, m_ipc;
   logic [31:0] m_pend[$];
   bit          n_fault, n_out, n_hold;
   logic [31:0] n_inst, n_ipc;
   logic [31:0] n_pend[$];
   bit          e_rv, e_wen, e_iv;
   logic [31:0] e_new;

   typedef struct {
      bit          redir;
      logic [31:0] tgt;
      bit          rdy;
      bit          rspv;
      logic [31:0] data;
      bit          err;
      bit          irdy;
      bit          x_rv;
      logic [31:0] x_addr;
      bit          x_wen;
      logic [31:0] x_new;
      bit          x_iv;
      logic [31:0] x_inst;
      logic [31:0] x_ipc;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input bit rd, input logic [31:0] t, input bit rdy, input bit rv,
                         input logic [31:0] d, input bit er, input bit ir);
      bus.redirect_valid  = rd;
      bus.redirect_target = t;
      bus.req_ready       = rdy;
      bus.rsp_valid       = rv;
      bus.rsp_data        = d;
      bus.rsp_err         = er;
      bus.inst_ready      = ir;
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_fault = 1'b0;
      m_out   = 1'b0;
      m_hold  = 1'b0;
      m_inst  = '0;
      m_ipc   = '0;
      m_pend  = {};
   endtask

   task automatic model_eval();
      e_rv = 1'b0; e_wen = 1'b0; e_iv = 1'b0; e_new = bus.pc;
      n_fault = m_fault; n_out = m_out; n_hold = m_hold;
      n_inst = m_inst; n_ipc = m_ipc; n_pend = m_pend;
      if (m_boot) begin
      end else if (m_fault) begin
         if (bus.redirect_valid) begin
            e_wen = 1'b1; e_new = bus.redirect_target; n_fault = 1'b0;
         end
      end else if (m_out) begin
         if (bus.redirect_valid) n_pend = {bus.redirect_target};
         if (bus.rsp_valid) begin
            n_out = 1'b0;
            if (n_pend.size() != 0) begin
               e_wen = 1'b1; e_new = n_pend[0]; n_pend = {};
            end else if (bus.rsp_err) begin
               n_fault = 1'b1;
            end else begin
               n_hold = 1'b1; n_inst = bus.rsp_data; n_ipc = bus.pc;
            end
         end
      end else if (m_hold) begin
         e_iv = !bus.redirect_valid;
         if (bus.redirect_valid) begin
            e_wen = 1'b1; e_new = bus.redirect_target; n_hold = 1'b0;
         end else if (bus.inst_ready) begin
            e_wen = 1'b1; e_new = 32'((64'(bus.pc) + 64'd4) % 64'h1_0000_0000); n_hold = 1'b0;
         end
      end else begin
         if (bus.redirect_valid) begin
            e_wen = 1'b1; e_new = bus.redirect_target;
         end else if (bus.pc % 4 != 0) begin
            n_fault = 1'b1;
         end else begin
            e_rv = 1'b1;
            if (bus.req_ready) n_out = 1'b1;
         end
      end
   endtask

   task automatic model_commit();
      m_boot = 1'b0; m_fault = n_fault; m_out = n_out; m_hold = n_hold;
      m_inst = n_inst; m_ipc = n_ipc; m_pend = n_pend;
   endtask

   // called at posedge+1 with inputs set; returns at the next posedge+1
   task automatic tick(input string tag);
      #1;
      s_rv = bus.req_valid; s_addr = bus.req_addr; s_wen = bus.pc_wen; s_new = bus.pc_new;
      s_iv = bus.inst_valid; s_inst = bus.inst; s_ipc = bus.inst_pc; s_flt = bus.fetch_fault;
      model_eval();
      check({tag, " req_valid"}, 64'(s_rv), 64'(e_rv));
      if (e_rv) check({tag, " req_addr"}, 64'(s_addr), 64'(bus.pc));
      check({tag, " pc_wen"}, 64'(s_wen), 64'(e_wen));
      check({tag, " pc_new"}, 64'(s_new), 64'(e_new));
      check({tag, " inst_valid"}, 64'(s_iv), 64'(e_iv));
      check({tag, " fetch_fault"}, 64'(s_flt), 64'(m_fault));
      check({tag, " inst/inst_pc"}, {s_inst, s_ipc}, {m_inst, m_ipc});
      @(posedge clk);
      #1;
      if (s_wen) bus.pc = s_new;
      model_commit();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_valid"}, 64'(bus.req_valid), 64'd0);
      check({tag, " pc_wen"}, 64'(bus.pc_wen), 64'd0);
      check({tag, " inst_valid"}, 64'(bus.inst_valid), 64'd0);
      check({tag, " fetch_fault"}, 64'(bus.fetch_fault), 64'd0);
      check({tag, " inst/inst_pc"}, {bus.inst, bus.inst_pc}, 64'd0);
   endtask

   initial begin
      bus.pc = 32'h8000_0000;
      set_in(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      tbl[0] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{0, 0, 0, 0, 0, 0, 0,   1, 32'h8000_0000, 0, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 0,   1, 32'h8000_0000, 0, 0, 0, 0, 0};
      tbl[3] = '{0, 0, 0, 0, 0, 0, 0,   1, 32'h8000_0000, 0, 0, 0, 0, 0};
      tbl[4] = '{0, 0, 1, 0, 0, 0, 0,   1, 32'h8000_0000, 0, 0, 0, 0, 0};
      tbl[5] = '{0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{0, 0, 0, 1, 32'h0000_0413, 0, 0,   0, 0, 0, 0, 0, 0, 0};
      tbl[7] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 32'h8000_0004, 1, 32'h0000_0413, 32'h8000_0000};
      tbl[8] = '{0, 0, 1, 0, 0, 0, 0,   1, 32'h8000_0004, 0, 0, 0, 0, 0};
      tbl[9] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};

      #2;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic fetch, stalled request, handoff and next request
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].redir, tbl[i].tgt, tbl[i].rdy, tbl[i].rspv, tbl[i].data, tbl[i].err, tbl[i].irdy);
         tick($sformatf("vec%0d", i));
         check($sformatf("vec%0d tbl req_valid", i), 64'(s_rv), 64'(tbl[i].x_rv));
         if (tbl[i].x_rv) check($sformatf("vec%0d tbl req_addr", i), 64'(s_addr), 64'(tbl[i].x_addr));
         check($sformatf("vec%0d tbl pc_wen", i), 64'(s_wen), 64'(tbl[i].x_wen));
         if (tbl[i].x_wen) check($sformatf("vec%0d tbl pc_new", i), 64'(s_new), 64'(tbl[i].x_new));
         check($sformatf("vec%0d tbl inst_valid", i), 64'(s_iv), 64'(tbl[i].x_iv));
         if (tbl[i].x_iv) check($sformatf("vec%0d tbl inst", i), {s_inst, s_ipc}, {tbl[i].x_inst, tbl[i].x_ipc});
      end

      // redirect while waiting: response discarded, pending target written
      set_in(1, 32'h8000_1000, 0, 0, 0, 0, 0); tick("wred1");
      check("wred1 no write", 64'(s_wen), 64'd0);
      set_in(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0); tick("wred2");
      check("wred2 pc_wen", 64'(s_wen), 64'd1);
      check("wred2 pc_new", 64'(s_new), 64'h8000_1000);
      check("wred2 inst_valid", 64'(s_iv), 64'd0);
      set_in(0, 0, 1, 0, 0, 0, 0); tick("wred3");
      check("wred3 req_addr", 64'(s_addr), 64'h8000_1000);
      check("wred3 no deadbeef", 64'(s_inst == 32'hDEAD_BEEF), 64'd0);
      set_in(0, 0, 0, 1, 32'h0010_0093, 0, 0); tick("wred4");

      // redirect and inst_ready together in HOLD: redirect wins
      set_in(1, 32'h8000_0100, 0, 0, 0, 0, 1); tick("hred1");
      check("hred1 inst_valid", 64'(s_iv), 64'd0);
      check("hred1 pc_new", 64'(s_new), 64'h8000_0100);
      set_in(0, 0, 0, 0, 0, 0, 0); tick("hred2");
      check("hred2 req_addr", 64'(s_addr), 64'h8000_0100);

      // misaligned pc fault, recovery, bus-error fault, recovery to wrapping pc
      set_in(1, 32'h8000_0002, 0, 0, 0, 0, 0); tick("mis1");
      set_in(0, 0, 1, 0, 0, 0, 0); tick("mis2");
      check("mis2 req_valid", 64'(s_rv), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick("mis3");
         check("mis3 fault held", {63'd0, s_flt}, 64'd1);
         check("mis3 no request", 64'(s_rv), 64'd0);
      end
      set_in(1, 32'h8000_0000, 1, 0, 0, 0, 0); tick("mis4");
      check("mis4 pc_new", 64'(s_new), 64'h8000_0000);
      set_in(0, 0, 1, 0, 0, 0, 0); tick("mis5");
      check("mis5 fault cleared", 64'(s_flt), 64'd0);
      check("mis5 resumed", 64'(s_rv), 64'd1);
      set_in(0, 0, 0, 1, 32'h1234_5678, 1, 0); tick("err1");
      set_in(0, 0, 1, 0, 0, 0, 0); tick("err2");
      check("err2 fault", 64'(s_flt), 64'd1);
      check("err2 no request", 64'(s_rv), 64'd0);
      set_in(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0); tick("wrap1");
      set_in(0, 0, 1, 0, 0, 0, 0); tick("wrap2");
      check("wrap2 req_addr", 64'(s_addr), 64'hFFFF_FFFC);
      set_in(0, 0, 0, 1, 32'h0000_0013, 0, 0); tick("wrap3");
      set_in(0, 0, 0, 0, 0, 0, 1); tick("wrap4");
      check("wrap4 pc_new", 64'(s_new), 64'h0);
      set_in(0, 0, 1, 0, 0, 0, 0); tick("wrap5");
      check("wrap5 req_addr", 64'(s_addr), 64'h0);

      // reset in the middle of WAIT, then a stale response
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rstw");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(0, 0, 0, 1, 32'h0000_0BAD, 0, 0); tick("stale1");
      check("stale1 inst_valid", 64'(s_iv), 64'd0);
      tick("stale2");
      set_in(0, 0, 0, 0, 0, 0, 0); tick("stale3");
      check("stale3 still requesting", 64'(s_rv), 64'd1);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] t;
         t = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) t = t | 32'h2;
         if ($urandom_range(0, 31) == 0) t = 32'hFFFF_FFFC;
         set_in($urandom_range(0, 9) == 0, t, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
